intr_ctrl: RTL and testbench

//  Interrupt controller on the CPU's responder side of the intr1/intr2 lines.
//  - Detects rising edges on intr1/intr2 and latches them as pending.
//  - Prioritises (intr1 > intr2), raises irq with a fixed vector and waits for the CPU

---
 rtl/intr_ctrl.sv | 108 ++++++++++
 tb/tb_intr_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Two-line interrupt controller: rising-edge capture into pending bits, fixed priority
// (intr1 over intr2), and a request/acknowledge/return handshake with the CPU.
module intr_ctrl #(
   parameter int              PC_W = 10,
   parameter logic [PC_W-1:0] VEC1 = 10'h3F0,
   parameter logic [PC_W-1:0] VEC2 = 10'h3F8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            intr1,
   input  logic            intr2,
   input  logic [1:0]      mask,
   input  logic            irq_ack,
   input  logic            irq_ret,
   output logic            irq,
   output logic [PC_W-1:0] irq_vec,
   output logic            irq_id,
   output logic            in_service,
   output logic [1:0]      pending
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_prev1;
   logic            r_prev2;
   logic            r_irq;
   logic [PC_W-1:0] r_irq_vec;
   logic            r_irq_id;
   logic            r_in_service;
   logic [1:0]      r_pending;

   logic [1:0]      w_rise;
   logic [1:0]      w_clr;
   logic [1:0]      w_pending_nxt;
   logic [1:0]      w_enabled;

   always_comb begin
      w_rise    = {intr2 & ~r_prev2, intr1 & ~r_prev1};
      w_clr     = 2'b00;
      w_enabled = r_pending & mask;
      if (r_state == REQ && irq_ack) begin
         w_clr = r_irq_id ? 2'b10 : 2'b01;
      end
      // A rise landing on the same cycle as its clear keeps the bit set.
      w_pending_nxt = (r_pending & ~w_clr) | w_rise;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_prev1      <= intr1;
         r_prev2      <= intr2;
         r_irq        <= 1'b0;
         r_irq_vec    <= '0;
         r_irq_id     <= 1'b0;
         r_in_service <= 1'b0;
         r_pending    <= 2'b00;
      end else begin
         r_prev1   <= intr1;
         r_prev2   <= intr2;
         r_pending <= w_pending_nxt;
         case (r_state)
            IDLE: begin
               if (w_enabled != 2'b00) begin
                  r_state <= REQ;
                  r_irq   <= 1'b1;
                  if (w_enabled[0]) begin
                     r_irq_id  <= 1'b0;
                     r_irq_vec <= VEC1;
                  end else begin
                     r_irq_id  <= 1'b1;
                     r_irq_vec <= VEC2;
                  end
               end
            end
            REQ: begin
               // Request stays frozen until the CPU takes it.
               if (irq_ack) begin
                  r_state      <= SERVICE;
                  r_irq        <= 1'b0;
                  r_in_service <= 1'b1;
               end
            end
            SERVICE: begin
               if (irq_ret) begin
                  r_state      <= IDLE;
                  r_in_service <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign irq        = r_irq;
   assign irq_vec    = r_irq_vec;
   assign irq_id     = r_irq_id;
   assign in_service = r_in_service;
   assign pending    = r_pending;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: reset, priority, masking, back-to-back and set-wins cases.
module tb_intr_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       intr1;
   logic       intr2;
   logic [1:0] mask;
   logic       irq_ack;
   logic       irq_ret;
   logic       irq;
   logic [9:0] irq_vec;
   logic       irq_id;
   logic       in_service;
   logic [1:0] pending;

   int n_checks = 0;
   int n_fail   = 0;

   intr_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .intr1      (intr1),
      .intr2      (intr2),
      .mask       (mask),
      .irq_ack    (irq_ack),
      .irq_ret    (irq_ret),
      .irq        (irq),
      .irq_vec    (irq_vec),
      .irq_id     (irq_id),
      .in_service (in_service),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic e_irq, input logic [9:0] e_vec,
                            input logic e_id, input logic e_svc, input logic [1:0] e_pend);
      check({tag, ".irq"},        {31'd0, irq},        {31'd0, e_irq});
      check({tag, ".irq_vec"},    {22'd0, irq_vec},    {22'd0, e_vec});
      check({tag, ".irq_id"},     {31'd0, irq_id},     {31'd0, e_id});
      check({tag, ".in_service"}, {31'd0, in_service}, {31'd0, e_svc});
      check({tag, ".pending"},    {30'd0, pending},    {30'd0, e_pend});
   endtask

   initial begin
      reset = 1'b0; intr1 = 1'b0; intr2 = 1'b0; mask = 2'b11;
      irq_ack = 1'b0; irq_ret = 1'b0;

      // 1: reset then single intr1 pulse
      tick();
      check_out("reset", 1'b0, 10'h000, 1'b0, 1'b0, 2'b00);
      reset = 1'b1;
      tick();
      intr1 = 1'b1;
      tick();
      intr1 = 1'b0;
      check_out("t1_pend", 1'b0, 10'h000, 1'b0, 1'b0, 2'b01);
      tick();
      check_out("t1_irq", 1'b1, 10'h3F0, 1'b0, 1'b0, 2'b01);

      // 2: acknowledge and return; ret in REQ is ignored first
      irq_ret = 1'b1;
      tick();
      irq_ret = 1'b0;
      check_out("t2_ret_in_req", 1'b1, 10'h3F0, 1'b0, 1'b0, 2'b01);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check_out("t2_ack", 1'b0, 10'h3F0, 1'b0, 1'b1, 2'b00);
      tick();
      check_out("t2_svc_hold", 1'b0, 10'h3F0, 1'b0, 1'b1, 2'b00);
      irq_ret = 1'b1;
      tick();
      irq_ret = 1'b0;
      check_out("t2_ret", 1'b0, 10'h3F0, 1'b0, 1'b0, 2'b00);
      tick();
      check_out("t2_idle", 1'b0, 10'h3F0, 1'b0, 1'b0, 2'b00);

      // 3: simultaneous rises, intr1 first, then back-to-back intr2
      intr1 = 1'b1; intr2 = 1'b1;
      tick();
      intr1 = 1'b0; intr2 = 1'b0;
      check_out("t3_pend", 1'b0, 10'h3F0, 1'b0, 1'b0, 2'b11);
      tick();
      check_out("t3_irq1", 1'b1, 10'h3F0, 1'b0, 1'b0, 2'b11);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check_out("t3_ack1", 1'b0, 10'h3F0, 1'b0, 1'b1, 2'b10);
      tick();
      check_out("t3_svc1", 1'b0, 10'h3F0, 1'b0, 1'b1, 2'b10);
      irq_ret = 1'b1;
      tick();
      irq_ret = 1'b0;
      check_out("t3_ret1", 1'b0, 10'h3F0, 1'b0, 1'b0, 2'b10);
      tick();
      check_out("t3_irq2", 1'b1, 10'h3F8, 1'b1, 1'b0, 2'b10);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check_out("t3_ack2", 1'b0, 10'h3F8, 1'b1, 1'b1, 2'b00);
      irq_ret = 1'b1;
      tick();
      irq_ret = 1'b0;

      // 4: masked intr2 latches but does not request until unmasked
      mask = 2'b01;
      intr2 = 1'b1;
      tick();
      intr2 = 1'b0;
      check_out("t4_pend", 1'b0, 10'h3F8, 1'b1, 1'b0, 2'b10);
      tick();
      tick();
      check_out("t4_masked", 1'b0, 10'h3F8, 1'b1, 1'b0, 2'b10);
      mask = 2'b11;
      tick();
      check_out("t4_unmask", 1'b1, 10'h3F8, 1'b1, 1'b0, 2'b10);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      irq_ret = 1'b1;
      tick();
      irq_ret = 1'b0;
      check_out("t4_done", 1'b0, 10'h3F8, 1'b1, 1'b0, 2'b00);

      // 5: intr1 held high through reset release produces no event
      intr1 = 1'b1;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      tick();
      check_out("t5_held", 1'b0, 10'h000, 1'b0, 1'b0, 2'b00);
      intr1 = 1'b0;
      tick();
      intr1 = 1'b1;
      tick();
      intr1 = 1'b0;
      check_out("t5_pend", 1'b0, 10'h000, 1'b0, 1'b0, 2'b01);
      tick();
      check_out("t5_irq", 1'b1, 10'h3F0, 1'b0, 1'b0, 2'b01);

      // 6: reset in REQ, then intr2 rising during SERVICE
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_out("t6_reset_req", 1'b0, 10'h000, 1'b0, 1'b0, 2'b00);
      tick();
      intr1 = 1'b1;
      tick();
      intr1 = 1'b0;
      tick();
      check_out("t6_irq1", 1'b1, 10'h3F0, 1'b0, 1'b0, 2'b01);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      intr2 = 1'b1;
      tick();
      intr2 = 1'b0;
      check_out("t6_svc_pend", 1'b0, 10'h3F0, 1'b0, 1'b1, 2'b10);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      tick();
      check_out("t6_svc_wait", 1'b0, 10'h3F0, 1'b0, 1'b1, 2'b10);
      irq_ret = 1'b1;
      tick();
      irq_ret = 1'b0;
      check_out("t6_ret", 1'b0, 10'h3F0, 1'b0, 1'b0, 2'b10);
      tick();
      check_out("t6_irq2", 1'b1, 10'h3F8, 1'b1, 1'b0, 2'b10);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      irq_ret = 1'b1;
      tick();
      irq_ret = 1'b0;

      // 7: a rise coinciding with the acknowledge of the same line keeps it pending
      intr1 = 1'b1;
      tick();
      intr1 = 1'b0;
      tick();
      check_out("t7_irq", 1'b1, 10'h3F0, 1'b0, 1'b0, 2'b01);
      intr1 = 1'b1; irq_ack = 1'b1;
      tick();
      intr1 = 1'b0; irq_ack = 1'b0;
      check_out("t7_setwins", 1'b0, 10'h3F0, 1'b0, 1'b1, 2'b01);
      irq_ret = 1'b1;
      tick();
      irq_ret = 1'b0;
      tick();
      check_out("t7_reirq", 1'b1, 10'h3F0, 1'b0, 1'b0, 2'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
